// File: rtl/seq_alu.sv
// Multi-cycle execute-stage ALU: single-cycle shift/add/logic ops plus iterative MUL, DIV and REM.
// One operation in flight at a time. Results and flags stay registered until the consumer takes them.
module seq_alu #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] InA,
  input  logic [WIDTH-1:0] InB,
  input  logic             Cin,
  input  logic [3:0]       Oper,
  input  logic             invA,
  input  logic             invB,
  input  logic             sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             Zero,
  output logic             Ofl,
  output logic             CF,
  output logic             DivZ,
  output logic             IllOp,
  output logic [2:0]       o_dbg_state
);

  // Handshake: an op is taken on a rising edge with in_valid && in_ready; a result is
  // held with out_valid high until the edge where out_ready is also high.
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ROL = 4'b0000, OP_SLL = 4'b0001, OP_SRA = 4'b0010, OP_SRL = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100, OP_AND = 4'b0101, OP_OR = 4'b0110, OP_XOR = 4'b0111;
  localparam logic [3:0] OP_BTR = 4'b1000, OP_PASSB = 4'b1001, OP_MUL = 4'b1010;
  localparam logic [3:0] OP_DIV = 4'b1100, OP_REM = 4'b1101;

  typedef enum logic [2:0] {S_IDLE, S_EXEC1, S_MUL, S_DIV, S_DONE} state_t;

  state_t               r_state, w_state_nxt;
  logic [3:0]           r_op;
  logic                 r_cin, r_sign, r_neg;
  logic [WIDTH-1:0]     r_a, r_b;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_out;
  logic                 r_zero, r_ofl, r_cf, r_divz, r_ill;

  logic [WIDTH-1:0]     w_act_a, w_act_b, w_mag_a, w_mag_b;
  logic                 w_accept, w_is_divrem, w_iter_done, w_load_res;
  logic [SHAMT_W-1:0]   w_sh;
  logic [SHAMT_W:0]     w_sh_inv;
  logic [WIDTH-1:0]     w_rol, w_sra, w_btr;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_step, w_prod;
  logic [2*WIDTH:0]     w_div_shift;
  logic [WIDTH:0]       w_div_trial;
  logic [2*WIDTH-1:0]   w_div_step;
  logic [WIDTH-1:0]     w_res_out;
  logic                 w_res_ofl, w_res_cf, w_res_divz, w_res_ill;

  assign in_ready    = (r_state == S_IDLE) && !rst;
  assign w_accept    = in_valid && in_ready;
  assign w_act_a     = invA ? ~InA : InA;
  assign w_act_b     = invB ? ~InB : InB;
  // Signed MUL runs on magnitudes; the product sign is restored in the final cycle.
  assign w_mag_a     = (sign && w_act_a[WIDTH-1]) ? -w_act_a : w_act_a;
  assign w_mag_b     = (sign && w_act_b[WIDTH-1]) ? -w_act_b : w_act_b;
  assign w_is_divrem = (Oper == OP_DIV) || (Oper == OP_REM);
  assign w_iter_done = (r_cnt == CNT_W'(WIDTH));

  assign w_sh     = r_b[SHAMT_W-1:0];
  assign w_sh_inv = (SHAMT_W + 1)'(WIDTH) - {1'b0, w_sh};
  assign w_rol    = (r_a << w_sh) | (r_a >> w_sh_inv);
  assign w_sra    = $unsigned($signed(r_a) >>> w_sh);
  assign w_sum    = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_cin};

  always_comb begin
    w_btr = '0;
    for (int i = 0; i < WIDTH; i++) w_btr[i] = r_a[WIDTH-1-i];
  end

  // Shift-add: multiplier sits in the low half of r_acc and drains out one bit per cycle.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};
  assign w_prod     = r_neg ? -r_acc : r_acc;

  // Restoring division: r_acc = {remainder, dividend/quotient}.
  assign w_div_shift = {r_acc, 1'b0};
  assign w_div_trial = w_div_shift[2*WIDTH:WIDTH] - {1'b0, r_b};
  assign w_div_step  = w_div_trial[WIDTH] ? w_div_shift[2*WIDTH-1:0]
                                          : {w_div_trial[WIDTH-1:0], w_div_shift[WIDTH-1:1], 1'b1};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (Oper == OP_MUL)                    w_state_nxt = S_MUL;
          else if (w_is_divrem && w_act_b != '0) w_state_nxt = S_DIV;
          else                                   w_state_nxt = S_EXEC1;
        end
      end
      S_EXEC1: w_state_nxt = S_DONE;
      S_MUL:   if (w_iter_done) w_state_nxt = S_DONE;
      S_DIV:   if (w_iter_done) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_res_out  = '0;
    w_res_ofl  = 1'b0;
    w_res_cf   = 1'b0;
    w_res_divz = 1'b0;
    w_res_ill  = 1'b0;
    w_load_res = 1'b0;
    case (r_state)
      S_EXEC1: begin
        w_load_res = 1'b1;
        case (r_op)
          OP_ROL:   w_res_out = w_rol;
          OP_SLL:   w_res_out = r_a << w_sh;
          OP_SRA:   w_res_out = w_sra;
          OP_SRL:   w_res_out = r_a >> w_sh;
          OP_ADD: begin
            w_res_out = w_sum[WIDTH-1:0];
            w_res_cf  = w_sum[WIDTH];
            w_res_ofl = r_sign ? ((r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]))
                               : w_sum[WIDTH];
          end
          OP_AND:   w_res_out = r_a & r_b;
          OP_OR:    w_res_out = r_a | r_b;
          OP_XOR:   w_res_out = r_a ^ r_b;
          OP_BTR:   w_res_out = w_btr;
          OP_PASSB: w_res_out = r_b;
          // DIV/REM only reach this state with a zero divisor.
          OP_DIV: begin
            w_res_out  = '1;
            w_res_divz = 1'b1;
          end
          OP_REM: begin
            w_res_out  = r_a;
            w_res_divz = 1'b1;
          end
          default:  w_res_ill = 1'b1;
        endcase
      end
      S_MUL: begin
        w_load_res = w_iter_done;
        w_res_out  = w_prod[WIDTH-1:0];
        w_res_ofl  = r_sign ? (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}})
                            : (w_prod[2*WIDTH-1:WIDTH] != '0);
      end
      S_DIV: begin
        w_load_res = w_iter_done;
        w_res_out  = (r_op == OP_REM) ? r_acc[2*WIDTH-1:WIDTH] : r_acc[WIDTH-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op   <= '0;
      r_cin  <= 1'b0;
      r_sign <= 1'b0;
      r_neg  <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_out  <= '0;
      r_zero <= 1'b0;
      r_ofl  <= 1'b0;
      r_cf   <= 1'b0;
      r_divz <= 1'b0;
      r_ill  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op   <= Oper;
        r_cin  <= Cin;
        r_sign <= sign;
        r_cnt  <= '0;
        r_neg  <= (Oper == OP_MUL) && sign && (w_act_a[WIDTH-1] ^ w_act_b[WIDTH-1]);
        r_a    <= (Oper == OP_BTR) ? InA : (Oper == OP_MUL) ? w_mag_a : w_act_a;
        r_b    <= (Oper == OP_PASSB) ? InB : w_act_b;
        r_acc  <= (Oper == OP_MUL) ? {{WIDTH{1'b0}}, w_mag_b} : {{WIDTH{1'b0}}, w_act_a};
      end
      if ((r_state == S_MUL || r_state == S_DIV) && !w_iter_done) begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_acc <= (r_state == S_MUL) ? w_mul_step : w_div_step;
      end
      if (w_load_res) begin
        r_out  <= w_res_out;
        r_zero <= (w_res_out == '0);
        r_ofl  <= w_res_ofl;
        r_cf   <= w_res_cf;
        r_divz <= w_res_divz;
        r_ill  <= w_res_ill;
      end
    end
  end

  assign out_valid   = (r_state == S_DONE);
  assign Out         = r_out;
  assign Zero        = r_zero;
  assign Ofl         = r_ofl;
  assign CF          = r_cf;
  assign DivZ        = r_divz;
  assign IllOp       = r_ill;
  assign o_dbg_state = r_state;

endmodule
